// File: rtl/ff_result_drain.sv
// Drain stage for the ff result buses: snapshots q1..q4 into a small FIFO and
// serializes each 184-bit snapshot as six 32-bit valid/ready beats.
module ff_result_drain #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cap_valid,
    input  logic [63:0]              q1,
    input  logic [31:0]              q2,
    input  logic [7:0]               q3,
    input  logic [79:0]              q4,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_last,
    output logic [2:0]               out_idx,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned EW = 184;

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_nx;
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [EW-1:0]   entry_in, head, next_head;
    logic            handshake, push, pop, drop;
    logic [2:0]      idx_nx;
    logic [31:0]     data_nx;
    logic            last_nx;

    function automatic logic [31:0] beat_of(input logic [EW-1:0] e, input logic [2:0] i);
        logic [31:0] b;
        case (i)
            3'd0:    b = e[31:0];
            3'd1:    b = e[63:32];
            3'd2:    b = e[95:64];
            3'd3:    b = e[127:96];
            3'd4:    b = e[159:128];
            3'd5:    b = {8'h00, e[183:160]};
            default: b = '0;
        endcase
        return b;
    endfunction

    assign out_valid = (state == SEND);
    assign entry_in  = {q4, q3, q2, q1};
    assign head      = mem[rd_ptr];

    always_comb begin
        handshake = out_valid & out_ready;
        pop       = handshake && (out_idx == 3'd5);
        push      = cap_valid && ((level < LW'(DEPTH)) || pop);
        drop      = cap_valid && (level == LW'(DEPTH)) && !pop;
        // With only the popping entry stored, the follow-on snapshot is the one
        // being pushed right now and is not in the RAM yet.
        if (level > LW'(1))
            next_head = mem[rd_ptr + PW'(1)];
        else
            next_head = entry_in;
    end

    always_comb begin
        state_nx = state;
        idx_nx   = out_idx;
        data_nx  = out_data;
        last_nx  = out_last;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    state_nx = SEND;
                    idx_nx   = 3'd0;
                    data_nx  = beat_of(head, 3'd0);
                    last_nx  = 1'b0;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (out_idx == 3'd5) begin
                        idx_nx  = 3'd0;
                        last_nx = 1'b0;
                        if ((level > LW'(1)) || push) begin
                            data_nx = beat_of(next_head, 3'd0);
                        end else begin
                            state_nx = IDLE;
                            data_nx  = '0;
                        end
                    end else begin
                        idx_nx  = out_idx + 3'd1;
                        data_nx = beat_of(head, out_idx + 3'd1);
                        last_nx = (out_idx == 3'd4);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_idx  <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            level    <= '0;
            drop_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_nx;
            out_idx  <= idx_nx;
            out_data <= data_nx;
            out_last <= last_nx;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= entry_in;
    end

endmodule

// File: tb/tb_ff_result_drain.sv
// Directed bench for ff_result_drain (DEPTH=4, CNT_W=4) with immediate-assertion checks.
module tb_ff_result_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cap_valid;
    logic [63:0] q1;
    logic [31:0] q2;
    logic [7:0]  q3;
    logic [79:0] q4;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [2:0]  out_idx;
    logic [2:0]  level;
    logic [3:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_b [6] = '{32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF,
                               32'h8899AA5A, 32'h44556677, 32'h00112233};

    ff_result_drain #(.DEPTH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_valid (cap_valid),
        .q1        (q1),
        .q2        (q2),
        .q3        (q3),
        .q4        (q4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expects a complete 6-beat frame already presented with out_ready high;
    // q2 of the frame is given, other fields are the reference snapshot.
    task automatic drain_frame(input string tag, input logic [31:0] q2_exp);
        logic [31:0] e;
        for (int b = 0; b < 6; b++) begin
            e = (b == 2) ? q2_exp : exp_b[b];
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_idx"},   64'(out_idx),   64'(b));
            chk({tag, "_data"},  64'(out_data),  64'(e));
            chk({tag, "_last"},  64'(out_last),  64'(b == 5));
            tick();
        end
    endtask

    initial begin
        int hs;
        int c;
        logic [31:0] pd;
        logic [2:0]  pi;
        logic        stalled;

        rst_n = 1'b0; cap_valid = 1'b0; out_ready = 1'b0;
        q1 = 64'h0123456789ABCDEF; q2 = 32'hDEADBEEF; q3 = 8'h5A;
        q4 = 80'h112233445566778899AA;
        tick(); tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_last",  64'(out_last),  64'd0);
        chk("rst_idx",   64'(out_idx),   64'd0);
        chk("rst_level", 64'(level),     64'd0);
        chk("rst_drop",  64'(drop_cnt),  64'd0);
        rst_n = 1'b1;
        tick();

        // Single snapshot: 2-cycle latency then six beats
        out_ready = 1'b1; cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        chk("single_level1", 64'(level), 64'd1);
        chk("single_novalid", 64'(out_valid), 64'd0);
        tick();
        drain_frame("single", 32'hDEADBEEF);
        chk("single_idle", 64'(out_valid), 64'd0);
        chk("single_level0", 64'(level), 64'd0);

        // Backpressure with ready pattern 1,0,0,1,0,0,...
        cap_valid = 1'b1; out_ready = 1'b0;
        tick();
        cap_valid = 1'b0;
        hs = 0; c = 0; stalled = 1'b0; pd = '0; pi = '0;
        while (hs < 6 && c < 80) begin
            out_ready = (c % 3 == 0);
            if (out_valid) begin
                chk("bp_idx",  64'(out_idx),  64'(hs));
                chk("bp_data", 64'(out_data), 64'(hs == 2 ? 32'hDEADBEEF : exp_b[hs]));
                if (stalled) begin
                    chk("bp_hold_data", 64'(out_data), 64'(pd));
                    chk("bp_hold_idx",  64'(out_idx),  64'(pi));
                end
                stalled = !out_ready;
                pd = out_data; pi = out_idx;
                if (out_ready) hs++;
            end
            tick();
            c++;
        end
        chk("bp_handshakes", 64'(hs), 64'd6);
        chk("bp_idle", 64'(out_valid), 64'd0);
        chk("bp_level0", 64'(level), 64'd0);

        // Overflow: 7 captures into a 4-deep FIFO with the consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            q2 = 32'(i); cap_valid = 1'b1;
            tick();
        end
        cap_valid = 1'b0;
        chk("ovf_level", 64'(level), 64'd4);
        chk("ovf_drop",  64'(drop_cnt), 64'd3);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++)
            drain_frame("ovf", 32'(k + 1));
        chk("ovf_idle",  64'(out_valid), 64'd0);
        chk("ovf_level0", 64'(level), 64'd0);

        // Simultaneous push/pop while full
        out_ready = 1'b0;
        for (int i = 11; i <= 14; i++) begin
            q2 = 32'(i); cap_valid = 1'b1;
            tick();
        end
        cap_valid = 1'b0;
        chk("pp_full", 64'(level), 64'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pp_idx5", 64'(out_idx), 64'd5);
        q2 = 32'd15; cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        chk("pp_level", 64'(level), 64'd4);
        chk("pp_drop",  64'(drop_cnt), 64'd3);
        for (int k = 0; k < 4; k++)
            drain_frame("pp", 32'(k + 12));
        chk("pp_level0", 64'(level), 64'd0);

        // Saturation: fill, then 20 drops on top of the 3 already counted
        out_ready = 1'b0;
        for (int i = 21; i <= 24; i++) begin
            q2 = 32'(i); cap_valid = 1'b1;
            tick();
        end
        for (int i = 1; i <= 20; i++) begin
            q2 = 32'hFFFF_0000 + 32'(i); cap_valid = 1'b1;
            tick();
            if (i == 11) chk("sat_drop14", 64'(drop_cnt), 64'hE);
        end
        cap_valid = 1'b0;
        chk("sat_drop", 64'(drop_cnt), 64'hF);
        chk("sat_level", 64'(level), 64'd4);
        chk("sat_head_q2", 64'(out_data), 64'h89ABCDEF);

        // Reset mid-frame during beat 3
        out_ready = 1'b1;
        tick(); tick(); tick();
        chk("mr_idx3", 64'(out_idx), 64'd3);
        rst_n = 1'b0;
        tick();
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_data",  64'(out_data),  64'd0);
        chk("mr_last",  64'(out_last),  64'd0);
        chk("mr_idx",   64'(out_idx),   64'd0);
        chk("mr_level", 64'(level),     64'd0);
        chk("mr_drop",  64'(drop_cnt),  64'd0);
        rst_n = 1'b1;
        tick();
        chk("mr_stay_idle", 64'(out_valid), 64'd0);
        q2 = 32'hDEADBEEF; cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
        chk("mr_level1", 64'(level), 64'd1);
        tick();
        drain_frame("mr", 32'hDEADBEEF);
        chk("mr_idle", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ff_result_drain.md
# ff_result_drain

Downstream drain stage for the `ff` emulation test design. It samples the four registered result buses (`q1` 64 b, `q2` 32 b, `q3` 8 b, `q4` 80 b) on a capture strobe, buffers each 184-bit snapshot in a small FIFO, and serializes each snapshot onto a 32-bit valid/ready stream of six beats for host-side readback. Snapshots that arrive while the FIFO is full are dropped and counted.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16: drop-counter width.

Ports:
- `clk`  in  1  Single design clock; all logic on its rising edge.
- `rst_n`  in  1  Synchronous, active-low reset.
- `cap_valid`  in  1  Capture strobe; snapshot `q1..q4` this cycle.
- `q1`  in  64  Result bus 1 from `ff`.
- `q2`  in  32  Result bus 2 from `ff`.
- `q3`  in  8  Result bus 3 from `ff`.
- `q4`  in  80  Result bus 4 from `ff`.
- `out_valid`  out  1  Beat valid.
- `out_ready`  in  1  Consumer ready.
- `out_data`  out  32  Beat payload.
- `out_last`  out  1  High on beat 5 of a snapshot.
- `out_idx`  out  3  Beat index 0..5.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `drop_cnt`  out  CNT_W  Dropped snapshots, saturating.

## Operation
- Reset (`rst_n` low at an edge): `out_valid`=0, `out_data`=0, `out_last`=0, `out_idx`=0, `level`=0, `drop_cnt`=0, FSM to IDLE, FIFO pointers cleared. FIFO payload RAM is not cleared.
- Push: `cap_valid` high and (`level` < DEPTH, or a pop occurs in the same cycle). The push writes `{q4,q3,q2,q1}`.
- Drop: `cap_valid` high, FIFO full, and no pop in the same cycle. Nothing is written. `drop_cnt` increments, saturating at all-ones.
- Beat map for the head entry:
  - beat0 = `q1[31:0]`
  - beat1 = `q1[63:32]`
  - beat2 = `q2`
  - beat3 = `{q4[23:0], q3}`
  - beat4 = `q4[55:24]`
  - beat5 = `{8'h00, q4[79:56]}`
- Pop: a handshake (`out_valid & out_ready`) on beat5 frees the head entry.
- FSM states:
  - IDLE: `out_valid`=0. Go to SEND with beat index 0 when `level` ≠ 0.
  - SEND: `out_valid`=1. Each handshake advances the index by 1. After the beat5 handshake:
    - stay in SEND with index 0 if another entry remains (`level` > 1 before the pop, or a simultaneous push into an otherwise-empty FIFO);
    - otherwise go to IDLE.
- `out_data`, `out_idx`, `out_last` are registered. While `out_valid` is high and `out_ready` is low they must hold stable; `out_valid` never drops without a handshake.
- `level` updates in the same cycle as the push/pop: +1 for push only, −1 for pop only, unchanged for both or neither.
- Pointers wrap modulo DEPTH. The full/empty decision uses `level`, not pointer equality.

## Timing
- Capture at edge N: `level`=1 after edge N. `out_valid` with beat0 is first high after edge N+1, giving a 2-cycle capture-to-first-beat latency.
- With `out_ready` held high, one snapshot drains in exactly 6 cycles. Consecutive buffered snapshots stream with no idle cycle between beat5 and the next beat0.
- Maximum sustained capture rate without drops is one snapshot per 6 cycles. Short bursts are absorbed up to DEPTH.
- Reset taking effect mid-snapshot aborts it: after that edge `out_valid`=0 and the partial snapshot is discarded. The consumer must treat `out_idx`=0 as the frame start.
- `drop_cnt` updates at the edge where the drop occurs.

## Test plan
- Single snapshot: `q1`=64'h0123456789ABCDEF, `q2`=32'hDEADBEEF, `q3`=8'h5A, `q4`=80'h112233445566778899AA, one `cap_valid`, `out_ready`=1.
  - Required beats: 89ABCDEF, 01234567, DEADBEEF, 8899AA5A, 44556677, 00112233.
  - `out_last` only on beat 5. First beat 2 cycles after capture; `level` returns to 0.
- Backpressure: same snapshot with `out_ready` toggled 1,0,0,1,…
  - Each beat is held stable while stalled.
  - Exactly 6 handshakes occur, in order, with no duplicates.
- Overflow, DEPTH=4, `out_ready`=0: 7 consecutive captures with `q2`=1..7.
  - `level`=4 and `drop_cnt`=3.
  - After releasing `out_ready`, snapshots `q2`=1,2,3,4 stream back-to-back in 24 cycles.
- Simultaneous push/pop at full: FIFO full, capture asserted on the beat5 handshake cycle.
  - The push is accepted, `level` stays 4 and `drop_cnt` is unchanged.
- Saturation, CNT_W=4: force 20 drops.
  - `drop_cnt` holds at 4'hF.
- Reset mid-frame: assert `rst_n`=0 during beat 3.
  - All outputs are 0 after that edge.
  - After reset release and a new capture, the stream restarts cleanly at beat 0.
